// File: rtl/alu_result_queue_pkg.sv
// Shared constants and the entry record for the ALU result queue.
// Storage words are laid out as {zero, result}, matching entry_t.
package alu_result_queue_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_DEPTH = 4;

    typedef struct packed {
        logic                     zero;
        logic [DEFAULT_WIDTH-1:0] result;
    } entry_t;

endpackage

// File: rtl/alu_rq_mem.sv
// Circular storage for the result queue: one write port, one asynchronous read port.
// Owns both pointers; the caller only issues qualified push/pop strobes.
module alu_rq_mem
    import alu_result_queue_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int DW    = DEFAULT_WIDTH + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [DW-1:0] mem_reg [DEPTH];

    // DEPTH is a power of two, so plain increment wraps DEPTH-1 -> 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
        end
    end

    // Entries are individually resettable so the head never reads X after reset.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    mem_reg[gi] <= '0;
                end else if (push && (wr_ptr_reg == AW'(gi))) begin
                    mem_reg[gi] <= wdata;
                end
            end
        end
    endgenerate

    assign rdata = mem_reg[rd_ptr_reg];

endmodule

// File: rtl/alu_result_queue.sv
// Result queue between the ALU and its consumer: occupancy count, handshakes,
// and a sticky drop_err flag for pushes attempted while full.
module alu_result_queue
    import alu_result_queue_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_result,
    input  logic                       in_zero,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_result,
    output logic                       out_zero,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       drop_err,
    input  logic                       clr_err
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic          drop_err_reg;
    logic          drop_err_next;
    logic          push;
    logic          pop;
    logic          drop;
    logic [WIDTH:0] rdata;

    // Handshake readiness comes from registered occupancy only.
    assign in_ready  = (count_reg != CW'(DEPTH));
    assign out_valid = (count_reg != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign drop      = in_valid && !in_ready;

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    // A drop in the same cycle as clr_err keeps the flag set.
    always_comb begin
        drop_err_next = drop_err_reg;
        if (drop) begin
            drop_err_next = 1'b1;
        end else if (clr_err) begin
            drop_err_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_reg    <= '0;
            drop_err_reg <= 1'b0;
        end else begin
            count_reg    <= count_next;
            drop_err_reg <= drop_err_next;
        end
    end

    alu_rq_mem #(
        .DEPTH (DEPTH),
        .DW    (WIDTH + 1)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata ({in_zero, in_result}),
        .rdata (rdata)
    );

    assign out_zero   = rdata[WIDTH];
    assign out_result = rdata[WIDTH-1:0];
    assign count      = count_reg;
    assign drop_err   = drop_err_reg;

endmodule

// File: tb/tb_alu_result_queue.sv
// Directed bench for alu_result_queue: a reference occupancy model plus a
// scoreboard queue of expected head entries, checked once per clock cycle.
module tb_alu_result_queue;
    import alu_result_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int WIDTH = 16;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic [WIDTH-1:0] in_result;
    logic             in_zero;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_result;
    logic             out_zero;
    logic             out_ready;
    logic [$clog2(DEPTH):0] count;
    logic             drop_err;
    logic             clr_err;

    int     errors = 0;
    int     checks = 0;
    int     exp_count = 0;
    logic   exp_drop = 1'b0;
    entry_t sb[$];

    alu_result_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_result  (in_result),
        .in_zero    (in_zero),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_result (out_result),
        .out_zero   (out_zero),
        .out_ready  (out_ready),
        .count      (count),
        .drop_err   (drop_err),
        .clr_err    (clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check the pre-edge state against the model,
    // then advance the model across the edge and check drop_err.
    task automatic cycle(input logic v, input logic [WIDTH-1:0] d, input logic z,
                         input logic ordy, input logic clr);
        entry_t head;
        entry_t e;
        logic   exp_ready;
        logic   exp_valid;
        in_valid  = v;
        in_result = d;
        in_zero   = z;
        out_ready = ordy;
        clr_err   = clr;
        #1;
        exp_ready = (exp_count != DEPTH);
        exp_valid = (exp_count != 0);
        chk("in_ready", 32'(in_ready), 32'(exp_ready));
        chk("out_valid", 32'(out_valid), 32'(exp_valid));
        chk("count", 32'(count), 32'(exp_count));
        if (exp_valid && ordy) begin
            head = sb.pop_front();
            chk("out_result", 32'(out_result), 32'(head.result));
            chk("out_zero", 32'(out_zero), 32'(head.zero));
            $display("pop  result=0x%04h zero=%0d count=%0d", out_result, out_zero, count);
        end
        if (v && exp_ready) begin
            e.zero   = z;
            e.result = d;
            sb.push_back(e);
            $display("push result=0x%04h zero=%0d count=%0d", d, z, count);
        end else if (v) begin
            $display("drop result=0x%04h count=%0d", d, count);
        end
        if (v && !exp_ready)  exp_drop = 1'b1;
        else if (clr)         exp_drop = 1'b0;
        exp_count = exp_count + ((v && exp_ready) ? 1 : 0) - ((exp_valid && ordy) ? 1 : 0);
        @(posedge clk);
        #1;
        chk("drop_err", 32'(drop_err), 32'(exp_drop));
    endtask

    task automatic reset_cycle(input logic v, input logic ordy);
        rst_n     = 1'b0;
        in_valid  = v;
        in_result = 16'h0077;
        in_zero   = 1'b0;
        out_ready = ordy;
        clr_err   = 1'b0;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        sb.delete();
        exp_count = 0;
        exp_drop  = 1'b0;
        $display("reset count=%0d out_valid=%0d", count, out_valid);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_drop_err", 32'(drop_err), 32'd0);
        chk("rst_out_result", 32'(out_result), 32'd0);
        chk("rst_out_zero", 32'(out_zero), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_result = '0; in_zero = 1'b0;
        out_ready = 1'b0; clr_err = 1'b0;
        @(posedge clk);
        reset_cycle(1'b0, 1'b0);
        cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);

        // Three pushes held, then drained in order.
        cycle(1'b1, 16'h0005, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 16'h0000, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);

        // Fill, overflow, clear-vs-drop priority, then drain.
        for (int i = 1; i <= 4; i++) cycle(1'b1, 16'(i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 16'h0005, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 16'h0006, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);

        // Steady push+pop at count=2 across pointer wrap.
        cycle(1'b1, 16'h0100, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 16'h0101, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b1, 16'(16'h0102 + i), 1'(i % 2), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);

        // Reset mid-operation with concurrent push and pop.
        for (int i = 0; i < 3; i++) cycle(1'b1, 16'(16'h0200 + i), 1'b0, 1'b0, 1'b0);
        reset_cycle(1'b1, 1'b1);
        cycle(1'b1, 16'h00AA, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_result_queue.md
ALU_RESULT_QUEUE -- requirements
Module: alu_result_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning number of queue entries (power of two, >= 2).
REQ-002 The block SHALL have parameter WIDTH, default 16, meaning ALU result width.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, reset that is synchronous and active-low.
REQ-005 The block SHALL have port in_valid, input, 1, upstream ALU result is valid this cycle.
REQ-006 The block SHALL have port in_result, input, WIDTH, ALU result word.
REQ-007 The block SHALL have port in_zero, input, 1, ALU zero flag accompanying in_result.
REQ-008 The block SHALL have port in_ready, output, 1, queue can accept a push this cycle.
REQ-009 The block SHALL have port out_valid, output, 1, head entry is valid.
REQ-010 The block SHALL have port out_result, output, WIDTH, head entry result.
REQ-011 The block SHALL have port out_zero, output, 1, head entry zero flag.
REQ-012 The block SHALL have port out_ready, input, 1, downstream consumes head this cycle when out_valid is high.
REQ-013 The block SHALL have port count, output, clog2(DEPTH)+1, current occupancy.
REQ-014 The block SHALL have port drop_err, output, 1, sticky flag: a push was attempted while full.
REQ-015 The block SHALL have port clr_err, input, 1, synchronous clear of drop_err.

Function
REQ-016 Push SHALL occur on a clock edge where in_valid && in_ready; {in_zero, in_result} is stored at the write pointer.
REQ-017 Pop SHALL occur on a clock edge where out_valid && out_ready; read pointer advances.
REQ-018 in_ready SHALL equal (count != DEPTH), registered-state derived, with no combinational dependence on out_ready.
REQ-019 out_valid SHALL equal (count != 0); out_result/out_zero SHALL reflect the head entry combinationally from storage.
REQ-020 Latency SHALL be one cycle: data pushed at edge N is visible at the output after edge N; no same-cycle fall-through when empty.
REQ-021 Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-022 Pointers SHALL be clog2(DEPTH) bits and wrap from DEPTH-1 to 0 without a gap.
REQ-023 count SHALL increment on push-only, decrement on pop-only, and never exceed DEPTH or go below 0.
REQ-024 in_valid while full SHALL not modify storage, pointers or count, and SHALL set drop_err at that edge.
REQ-025 clr_err SHALL clear drop_err at the next edge; if a drop occurs in the same cycle, set SHALL win.
REQ-026 out_result/out_zero values while out_valid is low SHALL be don't-care for consumers but SHALL not be X after reset.

Reset
REQ-027 With rst_n low at a clock edge, count, both pointers and drop_err SHALL become 0, giving in_ready=1 and out_valid=0.
REQ-028 Reset mid-operation SHALL discard all queued entries; push/pop in the reset cycle SHALL be ignored.
REQ-029 Storage array SHALL be reset to 0 so the head outputs read 0 after reset.

Structure
REQ-030 A shared package SHALL hold the default WIDTH (16) and DEPTH (4) constants and the entry record type {zero, result}.
REQ-031 The storage array with pointer logic SHALL be the sub-module alu_rq_mem (1 write, 1 async read port); control/count/flags live in the top.

Verification
REQ-032 Reset then idle -> in_ready=1, out_valid=0, count=0, drop_err=0, out_result=0x0000.
REQ-033 Push 0x0005/zero=0, 0x0000/zero=1, 0xFFFF/zero=0 with out_ready=0 -> count=3; then out_ready=1 drains in order 0x0005/0, 0x0000/1, 0xFFFF/0, count returns 0.
REQ-034 Push 4 words 0x0001..0x0004 -> count=4, in_ready=0; fifth push 0x0005 -> drop_err=1, count=4, drain yields 0x0001..0x0004 only.
REQ-035 Hold in_valid=1 and out_ready=1 for 10 cycles at count=2 with incrementing data -> count stays 2, outputs in push order across pointer wrap.
REQ-036 drop_err=1 and clr_err=1 in same cycle as another full push -> drop_err stays 1; next cycle clr_err alone -> drop_err=0.
REQ-037 With count=3, assert rst_n=0 for one edge concurrent with push and pop -> count=0, out_valid=0, next push 0x00AA appears at head after one edge.
